nts_api_demux_param: RTL

- Parametrised successor of the NTS engine external API demux.
- Decodes a single external register-bus request onto NUM_TARGETS internal endpoints, each with its own chip select and a shared we/address/write-data bus.
- Returns the read data and a valid pulse on the external side.
- New capabilities: configurable endpoint read latency, explicit error response for unmapped or out-of-range addresses, write acknowledge, and saturating diagnostic counters.

---
 rtl/nts_api_demux_param_pkg.sv | 38 +++
 rtl/nts_api_demux_param_if.sv | 24 ++
 rtl/nts_api_demux_param_addr_decoder.sv | 51 +++++
 rtl/nts_api_demux_param.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/nts_api_demux_param_pkg.sv
// Shared types and helpers for the parametrised NTS external API demux.
package nts_api_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DECODE  = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_RESPOND = 3'd4
   } state_t;

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam logic [31:0] DEFAULT_ERROR_DATA = 32'hDEAD_BEEF;

   // Upper bounds used to size the padded base/stop vectors handed to range_slice.
   localparam int MAX_TARGETS = 16;
   localparam int MAX_ADDR_W  = 32;
   localparam int FLAT_W      = MAX_TARGETS * MAX_ADDR_W;

   // Extract slice idx (aw bits wide) from a flattened, zero-padded address vector.
   function automatic logic [MAX_ADDR_W-1:0] range_slice(input logic [FLAT_W-1:0] flat,
                                                         input int idx,
                                                         input int aw);
      logic [FLAT_W-1:0]     shifted;
      logic [MAX_ADDR_W-1:0] mask;
      shifted = flat >> (idx * aw);
      mask    = (aw >= MAX_ADDR_W) ? '1 : ((32'd1 << aw) - 32'd1);
      return shifted[MAX_ADDR_W-1:0] & mask;
   endfunction

   // Saturating increment for the diagnostic counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
   endfunction

endpackage

// File: rtl/nts_api_demux_param_if.sv
// External register-bus request/response bundle of the API demux.
interface nts_api_demux_param_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic                  cs;
   logic                  we;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] write_data;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  read_data_valid;
   logic                  error;
   logic                  busy;

   modport master (
      output cs, we, address, write_data,
      input  read_data, read_data_valid, error, busy
   );

   modport slave (
      input  cs, we, address, write_data,
      output read_data, read_data_valid, error, busy
   );
endinterface

// File: rtl/nts_api_demux_param_addr_decoder.sv
// Combinational priority address decoder: maps an external address onto one
// endpoint (lowest index wins on overlap) and produces the endpoint-relative
// address. Assumes LOCAL_ADDR_WIDTH <= ADDR_WIDTH.
module nts_api_addr_decoder
   import nts_api_pkg::*;
#(
   parameter int NUM_TARGETS      = 6,
   parameter int ADDR_WIDTH       = 12,
   parameter int LOCAL_ADDR_WIDTH = 8,
   parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_BASE = '0,
   parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_STOP = '0
) (
   input  logic [ADDR_WIDTH-1:0]       address_i,
   output logic [NUM_TARGETS-1:0]      sel_o,
   output logic [LOCAL_ADDR_WIDTH-1:0] local_addr_o,
   output logic                        error_o
);

   localparam logic [FLAT_W-1:0] BASE_FLAT = FLAT_W'(TARGET_BASE);
   localparam logic [FLAT_W-1:0] STOP_FLAT = FLAT_W'(TARGET_STOP);

   logic                  found;
   logic [ADDR_WIDTH-1:0] base_a;
   logic [ADDR_WIDTH-1:0] stop_a;
   logic [ADDR_WIDTH-1:0] offset;

   // First matching range decides; an offset too wide for the local bus is an error.
   always_comb begin
      sel_o        = '0;
      local_addr_o = '0;
      error_o      = 1'b1;
      found        = 1'b0;
      base_a       = '0;
      stop_a       = '0;
      offset       = '0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         base_a = ADDR_WIDTH'(range_slice(BASE_FLAT, i, ADDR_WIDTH));
         stop_a = ADDR_WIDTH'(range_slice(STOP_FLAT, i, ADDR_WIDTH));
         if (!found && (address_i >= base_a) && (address_i <= stop_a)) begin
            found  = 1'b1;
            offset = address_i - base_a;
            if ((offset >> LOCAL_ADDR_WIDTH) == '0) begin
               error_o      = 1'b0;
               sel_o[i]     = 1'b1;
               local_addr_o = offset[LOCAL_ADDR_WIDTH-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/nts_api_demux_param.sv
// Parametrised NTS external API demux: accepts one external register request
// at a time, routes it to one of NUM_TARGETS endpoints, and returns a single
// response pulse carrying read data or an error indication.
module nts_api_demux_param
   import nts_api_pkg::*;
#(
   parameter int NUM_TARGETS      = 6,
   parameter int ADDR_WIDTH       = 12,
   parameter int LOCAL_ADDR_WIDTH = 8,
   parameter int DATA_WIDTH       = 32,
   parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_BASE =
      {12'h200, 12'h100, 12'h080, 12'h020, 12'h010, 12'h000},
   parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_STOP =
      {12'h3FF, 12'h1FF, 12'h0FF, 12'h03F, 12'h01F, 12'h00F},
   parameter int READ_LATENCY     = 0,
   parameter logic [DATA_WIDTH-1:0] ERROR_DATA = DATA_WIDTH'(DEFAULT_ERROR_DATA)
) (
   input  logic                              i_clk,
   input  logic                              i_areset,
   nts_api_demux_param_if.slave              external_api,
   output logic                              o_internal_api_we,
   output logic [LOCAL_ADDR_WIDTH-1:0]       o_internal_api_address,
   output logic [DATA_WIDTH-1:0]             o_internal_api_write_data,
   output logic [NUM_TARGETS-1:0]            o_internal_api_cs,
   input  logic [NUM_TARGETS*DATA_WIDTH-1:0] i_internal_api_read_data,
   output logic [CNT_W-1:0]                  o_err_count,
   output logic [CNT_W-1:0]                  o_collision_count
);

   state_t state_q, state_d;
   logic [2:0] wait_q, wait_d;

   logic accept;
   logic latch_dec;
   logic capture;

   // Request captured when accepted in IDLE.
   logic                  req_we_q;
   logic [ADDR_WIDTH-1:0] req_addr_q;
   logic [DATA_WIDTH-1:0] req_wdata_q;

   // Decode results and internal-bus drive registers.
   logic [NUM_TARGETS-1:0]      sel_q;
   logic                        err_q;
   logic                        int_we_q;
   logic [LOCAL_ADDR_WIDTH-1:0] int_addr_q;
   logic [DATA_WIDTH-1:0]       int_wdata_q;
   logic [DATA_WIDTH-1:0]       rdata_q;

   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] coll_cnt_q, coll_cnt_d;

   logic [NUM_TARGETS-1:0]      dec_sel;
   logic [LOCAL_ADDR_WIDTH-1:0] dec_local;
   logic                        dec_err;
   logic [DATA_WIDTH-1:0]       sel_rdata;

   nts_api_addr_decoder #(
      .NUM_TARGETS      (NUM_TARGETS),
      .ADDR_WIDTH       (ADDR_WIDTH),
      .LOCAL_ADDR_WIDTH (LOCAL_ADDR_WIDTH),
      .TARGET_BASE      (TARGET_BASE),
      .TARGET_STOP      (TARGET_STOP)
   ) u_decoder (
      .address_i    (req_addr_q),
      .sel_o        (dec_sel),
      .local_addr_o (dec_local),
      .error_o      (dec_err)
   );

   // FSM state and latency counter registers.
   always_ff @(posedge i_clk) begin
      if (i_areset) begin
         state_q <= ST_IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state logic plus one-cycle strobes steering the datapath registers.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      accept    = 1'b0;
      latch_dec = 1'b0;
      capture   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (external_api.cs) begin
               accept  = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            latch_dec = 1'b1;
            state_d   = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (READ_LATENCY == 0) begin
               capture = 1'b1;
               state_d = ST_RESPOND;
            end else begin
               wait_d  = 3'(READ_LATENCY);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wait_q <= 3'd1) begin
               capture = 1'b1;
               state_d = ST_RESPOND;
            end else begin
               wait_d = wait_q - 3'd1;
            end
         end
         ST_RESPOND: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Request payload is pure data; it is only consumed after a fresh capture.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         req_we_q    <= external_api.we;
         req_addr_q  <= external_api.address;
         req_wdata_q <= external_api.write_data;
      end
   end

   // Route the selected endpoint's read data (sel_q is one-hot or zero).
   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         if (sel_q[i]) begin
            sel_rdata = sel_rdata | i_internal_api_read_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Latch decode results, drive the internal bus, and form the response word.
   always_ff @(posedge i_clk) begin
      if (i_areset) begin
         sel_q       <= '0;
         err_q       <= 1'b0;
         int_we_q    <= 1'b0;
         int_addr_q  <= '0;
         int_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         if (latch_dec) begin
            sel_q       <= dec_sel;
            err_q       <= dec_err;
            int_we_q    <= req_we_q;
            int_addr_q  <= dec_local;
            int_wdata_q <= req_wdata_q;
         end
         if (capture) begin
            if (err_q) begin
               rdata_q <= ERROR_DATA;
            end else if (int_we_q) begin
               rdata_q <= '0;
            end else begin
               rdata_q <= sel_rdata;
            end
         end
      end
   end

   // Errors count when reported; any cs arriving outside IDLE is dropped and counted.
   always_comb begin
      err_cnt_d  = sat_inc(err_cnt_q, (state_q == ST_RESPOND) && err_q);
      coll_cnt_d = sat_inc(coll_cnt_q, external_api.cs && (state_q != ST_IDLE));
   end

   // Diagnostic counter registers.
   always_ff @(posedge i_clk) begin
      if (i_areset) begin
         err_cnt_q  <= '0;
         coll_cnt_q <= '0;
      end else begin
         err_cnt_q  <= err_cnt_d;
         coll_cnt_q <= coll_cnt_d;
      end
   end

   assign o_internal_api_cs         = (state_q == ST_ISSUE) ? sel_q : '0;
   assign o_internal_api_we         = int_we_q;
   assign o_internal_api_address    = int_addr_q;
   assign o_internal_api_write_data = int_wdata_q;

   assign external_api.read_data       = rdata_q;
   assign external_api.read_data_valid = (state_q == ST_RESPOND);
   assign external_api.error           = (state_q == ST_RESPOND) && err_q;
   assign external_api.busy            = (state_q != ST_IDLE) && (state_q != ST_RESPOND);

   assign o_err_count       = err_cnt_q;
   assign o_collision_count = coll_cnt_q;

endmodule
